// File: rtl/edu_result_scoreboard.sv
// Pairs two independent result streams through per-stream FIFOs, compares them in arrival
// order, and keeps saturating match/mismatch counters plus the first mismatching pair.
module edu_result_scoreboard #(
   parameter int W     = 11,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       gold_valid,
   output logic                       gold_ready,
   input  logic [W-1:0]               gold_data,
   input  logic                       dut_valid,
   output logic                       dut_ready,
   input  logic [W-1:0]               dut_data,
   output logic [$clog2(DEPTH):0]     gold_level,
   output logic [$clog2(DEPTH):0]     dut_level,
   output logic                       match_pulse,
   output logic                       mismatch_pulse,
   output logic [CNT_W-1:0]           match_count,
   output logic [CNT_W-1:0]           mismatch_count,
   output logic                       first_mm_valid,
   output logic [W-1:0]               first_mm_gold,
   output logic [W-1:0]               first_mm_dut
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [W-1:0]  gold_mem [DEPTH];
   logic [W-1:0]  dut_mem  [DEPTH];
   logic [PW-1:0] gold_wr, gold_rd, dut_wr, dut_rd;
   logic          gold_empty, gold_full, dut_empty, dut_full;
   logic          gold_push, dut_push, pair_pop, pair_equal;
   logic [W-1:0]  gold_head, dut_head;

   // The extra pointer MSB distinguishes full from empty when the index bits coincide.
   always_comb begin
      gold_empty = (gold_wr == gold_rd);
      dut_empty  = (dut_wr == dut_rd);
      gold_full  = (gold_wr[AW-1:0] == gold_rd[AW-1:0]) && (gold_wr[AW] != gold_rd[AW]);
      dut_full   = (dut_wr[AW-1:0] == dut_rd[AW-1:0]) && (dut_wr[AW] != dut_rd[AW]);
      gold_ready = !gold_full && !RESET;
      dut_ready  = !dut_full && !RESET;
      gold_push  = gold_valid && gold_ready;
      dut_push   = dut_valid && dut_ready;
      pair_pop   = !gold_empty && !dut_empty;
      gold_head  = gold_mem[gold_rd[AW-1:0]];
      dut_head   = dut_mem[dut_rd[AW-1:0]];
      pair_equal = (gold_head == dut_head);
      gold_level = gold_wr - gold_rd;
      dut_level  = dut_wr - dut_rd;
   end

   // Storage holds no control meaning, so it is written without reset.
   always_ff @(posedge CLK) begin
      if (gold_push) gold_mem[gold_wr[AW-1:0]] <= gold_data;
      if (dut_push)  dut_mem[dut_wr[AW-1:0]]   <= dut_data;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         gold_wr <= '0;
         gold_rd <= '0;
         dut_wr  <= '0;
         dut_rd  <= '0;
      end else begin
         if (gold_push) gold_wr <= gold_wr + 1'b1;
         if (dut_push)  dut_wr  <= dut_wr + 1'b1;
         if (pair_pop) begin
            gold_rd <= gold_rd + 1'b1;
            dut_rd  <= dut_rd + 1'b1;
         end
      end
   end

   // Compare result is registered at the pop edge; the first mismatch is captured once.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         match_pulse    <= 1'b0;
         mismatch_pulse <= 1'b0;
         match_count    <= '0;
         mismatch_count <= '0;
         first_mm_valid <= 1'b0;
         first_mm_gold  <= '0;
         first_mm_dut   <= '0;
      end else begin
         match_pulse    <= pair_pop && pair_equal;
         mismatch_pulse <= pair_pop && !pair_equal;
         if (pair_pop && pair_equal && (match_count != CNT_MAX))
            match_count <= match_count + 1'b1;
         if (pair_pop && !pair_equal) begin
            if (mismatch_count != CNT_MAX)
               mismatch_count <= mismatch_count + 1'b1;
            if (!first_mm_valid) begin
               first_mm_valid <= 1'b1;
               first_mm_gold  <= gold_head;
               first_mm_dut   <= dut_head;
            end
         end
      end
   end

endmodule
